// File: rtl/timer_entry_if.sv
// Keypad/tick inputs and counter-chain load/enable outputs of the microwave timer entry controller.
// The controller connects through the slave modport; the keypad/counter side uses master.
interface timer_entry_if;
   logic        key_valid;
   logic [3:0]  key_code;
   logic        sec_tick;
   logic        timer_zero;
   logic [15:0] digits;
   logic        load;
   logic        cnt_en_n;
   logic        done;
   logic [2:0]  state_o;

   modport master (
      output key_valid, key_code, sec_tick, timer_zero,
      input  digits, load, cnt_en_n, done, state_o
   );

   modport slave (
      input  key_valid, key_code, sec_tick, timer_zero,
      output digits, load, cnt_en_n, done, state_o
   );
endinterface

// File: rtl/timer_entry_ctrl.sv
// Keypad entry and run controller: collects mm:ss BCD digits, loads the down-counter chain,
// gates its count enable with the 1 Hz tick, and signals completion.
module timer_entry_ctrl #(
   parameter int unsigned DONE_CYCLES = 8
) (
   input logic         clk,
   input logic         rst,
   timer_entry_if.slave bus
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ENTRY = 3'd1,
      ST_LOAD  = 3'd2,
      ST_RUN   = 3'd3,
      ST_PAUSE = 3'd4,
      ST_DONE  = 3'd5
   } state_t;

   localparam logic [7:0] DONE_LOAD = 8'(DONE_CYCLES - 32'd1);

   state_t      state_r, state_s;
   logic [15:0] entry_r, entry_s;
   logic [2:0]  digit_cnt_r, digit_cnt_s;
   logic [7:0]  done_cnt_r, done_cnt_s;
   logic        key_digit_s, key_start_s, key_clear_s, key_any_s;

   // Key decode; codes 0xC-0xF never count as a key.
   always_comb begin
      key_digit_s = bus.key_valid && (bus.key_code <= 4'h9);
      key_start_s = bus.key_valid && (bus.key_code == 4'hA);
      key_clear_s = bus.key_valid && (bus.key_code == 4'hB);
      key_any_s   = key_digit_s || key_start_s || key_clear_s;
   end

   // Next-state and datapath update.
   always_comb begin
      state_s     = state_r;
      entry_s     = entry_r;
      digit_cnt_s = digit_cnt_r;
      done_cnt_s  = done_cnt_r;
      case (state_r)
         ST_IDLE: begin
            if (key_digit_s) begin
               entry_s     = {12'h000, bus.key_code};
               digit_cnt_s = 3'd1;
               state_s     = ST_ENTRY;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_ENTRY: begin
            if (key_clear_s) begin
               entry_s     = 16'h0000;
               digit_cnt_s = 3'd0;
               state_s     = ST_IDLE;
            end else if (key_start_s) begin
               if (entry_r != 16'h0000) begin
                  state_s = ST_LOAD;
               end else begin
                  state_s = ST_ENTRY;
               end
            end else if (key_digit_s && (digit_cnt_r < 3'd4)) begin
               entry_s     = {entry_r[11:0], bus.key_code};
               digit_cnt_s = digit_cnt_r + 3'd1;
            end else begin
               state_s = ST_ENTRY;
            end
         end
         ST_LOAD: begin
            state_s = ST_RUN;
         end
         ST_RUN: begin
            // Clear beats completion, completion beats pause.
            if (key_clear_s) begin
               entry_s     = 16'h0000;
               digit_cnt_s = 3'd0;
               state_s     = ST_IDLE;
            end else if (bus.timer_zero) begin
               done_cnt_s = DONE_LOAD;
               state_s    = ST_DONE;
            end else if (key_start_s) begin
               state_s = ST_PAUSE;
            end else begin
               state_s = ST_RUN;
            end
         end
         ST_PAUSE: begin
            if (key_start_s) begin
               state_s = ST_RUN;
            end else if (key_clear_s) begin
               entry_s     = 16'h0000;
               digit_cnt_s = 3'd0;
               state_s     = ST_IDLE;
            end else begin
               state_s = ST_PAUSE;
            end
         end
         ST_DONE: begin
            if ((done_cnt_r == 8'd0) || key_any_s) begin
               entry_s     = 16'h0000;
               digit_cnt_s = 3'd0;
               state_s     = ST_IDLE;
            end else begin
               done_cnt_s = done_cnt_r - 8'd1;
            end
         end
         default: begin
            entry_s     = 16'h0000;
            digit_cnt_s = 3'd0;
            state_s     = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         entry_r     <= 16'h0000;
         digit_cnt_r <= 3'd0;
         done_cnt_r  <= 8'd0;
      end else begin
         state_r     <= state_s;
         entry_r     <= entry_s;
         digit_cnt_r <= digit_cnt_s;
         done_cnt_r  <= done_cnt_s;
      end
   end

   // Moore decodes; cnt_en_n is the single combinational path from sec_tick.
   always_comb begin
      bus.digits   = entry_r;
      bus.load     = (state_r == ST_LOAD);
      bus.done     = (state_r == ST_DONE);
      bus.cnt_en_n = ~((state_r == ST_RUN) & bus.sec_tick);
      bus.state_o  = state_r;
   end

endmodule

// File: tb/tb_timer_entry_ctrl.sv
// Bench for timer_entry_ctrl: directed test-plan scenarios plus random keys/ticks,
// all checked each cycle against a digit-queue reference model.
module tb_timer_entry_ctrl;

   localparam int DONE_N = 8;
   localparam int M_IDLE = 0, M_ENTRY = 1, M_LOAD = 2, M_RUN = 3, M_PAUSE = 4, M_DONE = 5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   timer_entry_if bus();

   timer_entry_ctrl #(.DONE_CYCLES(DONE_N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp = 0;
   int n_err = 0;
   int load_seen = 0;
   int en_seen = 0;
   int done_seen = 0;

   // reference model: mode number, entered digits in order, DONE cycles remaining
   int m_mode = M_IDLE;
   int m_digits[$];
   int m_done_left = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int packed_entry();
      int v = 0;
      foreach (m_digits[i]) v = v * 16 + m_digits[i];
      return v;
   endfunction

   task automatic model_step(input bit kv, input int code, input bit tz, input bit r);
      bit is_key, is_digit, is_start, is_clear;
      is_key   = kv && (code <= 11);
      is_digit = is_key && (code <= 9);
      is_start = is_key && (code == 10);
      is_clear = is_key && (code == 11);
      if (r) begin
         m_mode = M_IDLE;
         m_digits.delete();
         m_done_left = 0;
         return;
      end
      case (m_mode)
         M_IDLE:
            if (is_digit) begin
               m_digits = {code};
               m_mode = M_ENTRY;
            end
         M_ENTRY:
            if (is_clear) begin
               m_digits.delete();
               m_mode = M_IDLE;
            end else if (is_start) begin
               if (packed_entry() != 0) m_mode = M_LOAD;
            end else if (is_digit && m_digits.size() < 4) begin
               m_digits.push_back(code);
            end
         M_LOAD: m_mode = M_RUN;
         M_RUN:
            if (is_clear) begin
               m_digits.delete();
               m_mode = M_IDLE;
            end else if (tz) begin
               m_done_left = DONE_N;
               m_mode = M_DONE;
            end else if (is_start) begin
               m_mode = M_PAUSE;
            end
         M_PAUSE:
            if (is_start) m_mode = M_RUN;
            else if (is_clear) begin
               m_digits.delete();
               m_mode = M_IDLE;
            end
         M_DONE: begin
            m_done_left--;
            if (m_done_left == 0 || is_key) begin
               m_digits.delete();
               m_mode = M_IDLE;
            end
         end
         default: m_mode = M_IDLE;
      endcase
   endtask

   // One clock: drive at negedge, compare all outputs, then advance the model at posedge.
   task automatic cycle(input bit kv, input logic [3:0] code, input bit tick, input bit tz, input bit r);
      @(negedge clk);
      rst = r;
      bus.key_valid = kv;
      bus.key_code = code;
      bus.sec_tick = tick;
      bus.timer_zero = tz;
      #1;
      chk("state", 32'(bus.state_o), m_mode);
      chk("digits", 32'(bus.digits), packed_entry());
      chk("load", 32'(bus.load), 32'(m_mode == M_LOAD));
      chk("done", 32'(bus.done), 32'(m_mode == M_DONE));
      chk("cnt_en_n", 32'(bus.cnt_en_n), 32'(!(m_mode == M_RUN && tick)));
      if (bus.load) load_seen++;
      if (!bus.cnt_en_n) en_seen++;
      if (bus.done) done_seen++;
      @(posedge clk);
      model_step(kv, int'(code), tz, r);
   endtask

   task automatic key(input logic [3:0] code);
      cycle(1'b1, code, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      int l0, e0, d0;
      bit kv, tick, tz, r;
      logic [3:0] code;
      bus.key_valid = 1'b0;
      bus.key_code = 4'h0;
      bus.sec_tick = 1'b0;
      bus.timer_zero = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_state", 32'(bus.state_o), 0);
      chk("rst_digits", 32'(bus.digits), 0);
      chk("rst_cnt_en_n", 32'(bus.cnt_en_n), 1);
      chk("rst_load_done", 32'({bus.load, bus.done}), 0);

      // entry and load
      l0 = load_seen;
      key(4'h1); key(4'h3); key(4'h0); key(4'h5); key(4'hA);
      #1;
      chk("tp_load_digits", 32'(bus.digits), 32'h1305);
      chk("tp_load_high", 32'(bus.load), 1);
      idle(1);
      #1;
      chk("tp_run_after_load", 32'(bus.state_o), M_RUN);

      // run, pause, resume
      e0 = en_seen;
      repeat (3) cycle(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
      key(4'hA);
      repeat (2) cycle(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
      key(4'hA);
      cycle(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
      chk("tp_tick_enables", en_seen - e0, 4);
      chk("tp_load_once", load_seen - l0, 1);

      // overflow and blank start
      do_reset();
      key(4'h1); key(4'h2); key(4'h3); key(4'h4); key(4'h5);
      #1;
      chk("tp_overflow", 32'(bus.digits), 32'h1234);
      do_reset();
      l0 = load_seen;
      key(4'h0); key(4'hA);
      #1;
      chk("tp_blank_state", 32'(bus.state_o), M_ENTRY);
      idle(2);
      chk("tp_blank_noload", load_seen - l0, 0);

      // completion
      do_reset();
      key(4'h0); key(4'h0); key(4'h0); key(4'h2); key(4'hA);
      idle(3);
      cycle(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
      #1;
      chk("tp_done_entered", 32'(bus.state_o), M_DONE);
      d0 = done_seen;
      idle(12);
      chk("tp_done_len", done_seen - d0, DONE_N);
      #1;
      chk("tp_done_idle", 32'(bus.state_o), M_IDLE);
      chk("tp_done_digits", 32'(bus.digits), 0);

      // clear priority in RUN, clear in PAUSE
      do_reset();
      key(4'h1); key(4'hA); idle(2);
      d0 = done_seen;
      cycle(1'b1, 4'hB, 1'b0, 1'b1, 1'b0);
      #1;
      chk("tp_clr_over_zero", 32'(bus.state_o), M_IDLE);
      idle(3);
      chk("tp_clr_no_done", done_seen - d0, 0);
      key(4'h2); key(4'hA); idle(2); key(4'hA);
      #1;
      chk("tp_paused", 32'(bus.state_o), M_PAUSE);
      key(4'hB);
      #1;
      chk("tp_clr_pause", 32'(bus.state_o), M_IDLE);

      // reset mid-RUN with tick, and mid-DONE
      key(4'h7); key(4'hA); idle(2);
      cycle(1'b0, 4'h0, 1'b1, 1'b0, 1'b1);
      #1;
      chk("tp_rst_run", 32'({bus.state_o, bus.cnt_en_n, bus.done}), 32'b000_1_0);
      chk("tp_rst_run_digits", 32'(bus.digits), 0);
      cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
      key(4'h1); key(4'hA); idle(1);
      cycle(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
      idle(2);
      cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
      #1;
      chk("tp_rst_done", 32'({bus.state_o, bus.cnt_en_n, bus.done}), 32'b000_1_0);
      chk("tp_rst_done_digits", 32'(bus.digits), 0);

      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         kv = ($urandom_range(0, 2) == 0);
         code = ($urandom_range(0, 3) == 0) ? 4'hA : 4'($urandom_range(0, 15));
         tick = ($urandom_range(0, 3) == 0);
         tz = ($urandom_range(0, 15) == 0);
         r = ($urandom_range(0, 199) == 0);
         cycle(kv, code, tick, tz, r);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
